// File: rtl/l2_cache_read_stage.sv
// L2 cache read stage: resolves hit/miss, returns same-cycle tag/dirty/LRU update
// strobes to the tag stage, reads line data and tracks load-sync/store-sync reservations.
package l2_cache_pkg;
  localparam int L2_WAYS     = 4;
  localparam int L2_SETS     = 16;
  localparam int L2_WAY_BITS = $clog2(L2_WAYS);
  localparam int L2_SET_BITS = $clog2(L2_SETS);
  localparam int L2_TAG_BITS = 16;
  localparam int LINE_BITS   = 128;
  localparam int ID_BITS     = 6;

  typedef logic [L2_TAG_BITS-1:0] l2_tag_t;
  typedef logic [L2_SET_BITS-1:0] l2_set_idx_t;
  typedef logic [L2_WAY_BITS-1:0] l2_way_idx_t;
  typedef logic [LINE_BITS-1:0]   cache_line_data_t;

  typedef enum logic [2:0] {
    L2REQ_LOAD        = 3'd0,
    L2REQ_STORE       = 3'd1,
    L2REQ_FLUSH       = 3'd2,
    L2REQ_DINVALIDATE = 3'd3,
    L2REQ_LOAD_SYNC   = 3'd4,
    L2REQ_STORE_SYNC  = 3'd5
  } l2req_type_t;

  typedef struct packed {
    logic [ID_BITS-1:0] id;
    l2req_type_t        packet_type;
    l2_tag_t            tag;
    l2_set_idx_t        set_idx;
  } l2req_packet_t;
endpackage

module l2_cache_read_stage
  import l2_cache_pkg::*;
#(
  parameter int SYNC_SLOTS = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                l2t_request_valid,
  input  l2req_packet_t                       l2t_request,
  input  logic [L2_WAYS-1:0]                  l2t_valid,
  input  l2_tag_t [L2_WAYS-1:0]               l2t_tag,
  input  logic [L2_WAYS-1:0]                  l2t_dirty,
  input  logic                                l2t_is_l2_fill,
  input  l2_way_idx_t                         l2t_fill_way,
  input  cache_line_data_t                    l2t_data_from_memory,
  input  logic                                l2t_is_restarted_flush,
  input  logic                                l2u_write_en,
  input  logic [L2_WAY_BITS+L2_SET_BITS-1:0]  l2u_write_index,
  input  cache_line_data_t                    l2u_write_data,
  output logic [L2_WAYS-1:0]                  l2r_update_dirty_en,
  output l2_set_idx_t                         l2r_update_dirty_set,
  output logic                                l2r_update_dirty_value,
  output logic [L2_WAYS-1:0]                  l2r_update_tag_en,
  output l2_set_idx_t                         l2r_update_tag_set,
  output logic                                l2r_update_tag_valid,
  output l2_tag_t                             l2r_update_tag_value,
  output logic                                l2r_update_lru_en,
  output l2_way_idx_t                         l2r_update_lru_hit_way,
  output logic                                l2r_request_valid,
  output l2req_packet_t                       l2r_request,
  output logic                                l2r_cache_hit,
  output l2_way_idx_t                         l2r_hit_way,
  output cache_line_data_t                    l2r_data,
  output logic                                l2r_is_l2_fill,
  output logic                                l2r_needs_writeback,
  output l2_tag_t                             l2r_writeback_tag,
  output logic                                l2r_store_sync_success
);
  localparam int SLOT_BITS = $clog2(SYNC_SLOTS);
  localparam int IDX_BITS  = L2_WAY_BITS + L2_SET_BITS;

  typedef logic [L2_TAG_BITS+L2_SET_BITS-1:0] line_addr_t;

  logic [L2_WAYS-1:0]   w_hit;
  l2_way_idx_t          w_hit_way;
  logic                 w_cache_hit;
  logic                 w_access;
  l2_way_idx_t          w_way;
  logic [L2_WAYS-1:0]   w_way_oh;
  line_addr_t           w_line;
  logic [SLOT_BITS-1:0] w_slot;
  logic                 w_active;
  logic                 w_is_load, w_is_store, w_is_flush, w_is_dinv, w_is_lsync, w_is_ssync;
  logic                 w_sync_match, w_sync_ok, w_line_write, w_set_resv;
  logic                 w_fill, w_flush_dirty, w_inval;
  logic                 w_needs_wb;
  l2_tag_t              w_wb_tag;
  logic [IDX_BITS-1:0]  w_rd_idx;

  logic                 r_res_valid [SYNC_SLOTS];
  line_addr_t           r_res_line  [SYNC_SLOTS];
  cache_line_data_t     r_sram      [L2_WAYS*L2_SETS];

  logic                 r_request_valid;
  l2req_packet_t        r_request;
  logic                 r_cache_hit;
  l2_way_idx_t          r_hit_way;
  cache_line_data_t     r_data;
  logic                 r_is_l2_fill;
  logic                 r_needs_writeback;
  l2_tag_t              r_writeback_tag;
  logic                 r_store_sync_success;

  always_comb begin
    w_hit     = '0;
    w_hit_way = '0;
    for (int i = 0; i < L2_WAYS; i++) begin
      w_hit[i] = l2t_valid[i] && (l2t_tag[i] == l2t_request.tag);
      if (w_hit[i]) w_hit_way = l2_way_idx_t'(i);
    end
  end

  assign w_is_load  = l2t_request.packet_type == L2REQ_LOAD;
  assign w_is_store = l2t_request.packet_type == L2REQ_STORE;
  assign w_is_flush = l2t_request.packet_type == L2REQ_FLUSH;
  assign w_is_dinv  = l2t_request.packet_type == L2REQ_DINVALIDATE;
  assign w_is_lsync = l2t_request.packet_type == L2REQ_LOAD_SYNC;
  assign w_is_ssync = l2t_request.packet_type == L2REQ_STORE_SYNC;

  assign w_cache_hit = |w_hit;
  assign w_access    = w_cache_hit || l2t_is_l2_fill;
  assign w_way       = l2t_is_l2_fill ? l2t_fill_way : w_hit_way;
  assign w_way_oh    = {{(L2_WAYS-1){1'b0}}, 1'b1} << w_way;
  assign w_line      = {l2t_request.tag, l2t_request.set_idx};
  assign w_slot      = SLOT_BITS'(l2t_request.id % ID_BITS'(SYNC_SLOTS));
  assign w_active    = l2t_request_valid && !reset;

  // A store-sync is only judged once the line is present (hit or arriving fill).
  assign w_sync_match  = r_res_valid[w_slot] && (r_res_line[w_slot] == w_line);
  assign w_sync_ok     = w_active && w_is_ssync && w_access && w_sync_match;
  assign w_line_write  = (w_active && w_is_store && w_access) || w_sync_ok;
  assign w_set_resv    = w_active && w_is_lsync && w_access;
  assign w_fill        = w_active && l2t_is_l2_fill;
  assign w_flush_dirty = w_active && w_is_flush && w_cache_hit && !l2t_is_l2_fill
                         && l2t_dirty[w_hit_way];
  assign w_inval       = w_active && w_is_dinv && w_cache_hit && !l2t_is_l2_fill;

  assign l2r_update_dirty_en    = (w_fill || w_line_write || w_flush_dirty) ? w_way_oh : '0;
  assign l2r_update_dirty_set   = l2t_request.set_idx;
  assign l2r_update_dirty_value = w_line_write;
  assign l2r_update_tag_en      = (w_fill || w_inval) ? w_way_oh : '0;
  assign l2r_update_tag_set     = l2t_request.set_idx;
  assign l2r_update_tag_valid   = w_fill;
  assign l2r_update_tag_value   = l2t_request.tag;
  assign l2r_update_lru_en      = w_fill || (w_active && w_cache_hit
                                  && (w_is_load || w_is_store || w_is_lsync || w_is_ssync));
  assign l2r_update_lru_hit_way = w_way;

  assign w_needs_wb = w_fill ? (l2t_valid[l2t_fill_way] && l2t_dirty[l2t_fill_way])
                             : (w_flush_dirty && !l2t_is_restarted_flush);
  assign w_wb_tag   = l2t_is_l2_fill ? l2t_tag[l2t_fill_way] : l2t_tag[w_hit_way];
  assign w_rd_idx   = {w_way, l2t_request.set_idx};

  always_ff @(posedge clk) begin
    if (l2u_write_en) r_sram[l2u_write_index] <= l2u_write_data;
  end

  // Read-during-write to the same line forwards the incoming write data.
  always_ff @(posedge clk) begin
    if (l2t_is_l2_fill)
      r_data <= l2t_data_from_memory;
    else if (l2u_write_en && (l2u_write_index == w_rd_idx))
      r_data <= l2u_write_data;
    else
      r_data <= r_sram[w_rd_idx];
  end

  always_ff @(posedge clk) begin
    r_request       <= l2t_request;
    r_hit_way       <= w_way;
    r_writeback_tag <= w_wb_tag;
    if (reset) begin
      r_request_valid      <= 1'b0;
      r_cache_hit          <= 1'b0;
      r_is_l2_fill         <= 1'b0;
      r_needs_writeback    <= 1'b0;
      r_store_sync_success <= 1'b0;
    end else begin
      r_request_valid      <= l2t_request_valid;
      r_cache_hit          <= l2t_request_valid && w_cache_hit;
      r_is_l2_fill         <= w_fill;
      r_needs_writeback    <= w_needs_wb;
      r_store_sync_success <= w_sync_ok;
    end
  end

  // A write to a line kills every reservation on it; a load-sync then claims its slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_SLOTS; i++) r_res_valid[i] <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_SLOTS; i++) begin
        if (w_line_write && r_res_valid[i] && (r_res_line[i] == w_line))
          r_res_valid[i] <= 1'b0;
        if (w_set_resv && (w_slot == SLOT_BITS'(i))) begin
          r_res_valid[i] <= 1'b1;
          r_res_line[i]  <= w_line;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && l2t_request_valid) assert ($onehot0(w_hit));
  end

  assign l2r_request_valid      = r_request_valid;
  assign l2r_request            = r_request;
  assign l2r_cache_hit          = r_cache_hit;
  assign l2r_hit_way            = r_hit_way;
  assign l2r_data               = r_data;
  assign l2r_is_l2_fill         = r_is_l2_fill;
  assign l2r_needs_writeback    = r_needs_writeback;
  assign l2r_writeback_tag      = r_writeback_tag;
  assign l2r_store_sync_success = r_store_sync_success;
endmodule

// File: tb/tb_l2_cache_read_stage.sv
// Bench for l2_cache_read_stage: directed requests, a per-cycle reference model
// of the hit/fill/flush/reservation rules, and literal spot checks.
module tb_l2_cache_read_stage;
  import l2_cache_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 l2t_request_valid;
  l2req_packet_t        l2t_request;
  logic [L2_WAYS-1:0]   l2t_valid;
  l2_tag_t [L2_WAYS-1:0] l2t_tag;
  logic [L2_WAYS-1:0]   l2t_dirty;
  logic                 l2t_is_l2_fill;
  l2_way_idx_t          l2t_fill_way;
  cache_line_data_t     l2t_data_from_memory;
  logic                 l2t_is_restarted_flush;
  logic                 l2u_write_en;
  logic [5:0]           l2u_write_index;
  cache_line_data_t     l2u_write_data;
  logic [L2_WAYS-1:0]   l2r_update_dirty_en;
  l2_set_idx_t          l2r_update_dirty_set;
  logic                 l2r_update_dirty_value;
  logic [L2_WAYS-1:0]   l2r_update_tag_en;
  l2_set_idx_t          l2r_update_tag_set;
  logic                 l2r_update_tag_valid;
  l2_tag_t              l2r_update_tag_value;
  logic                 l2r_update_lru_en;
  l2_way_idx_t          l2r_update_lru_hit_way;
  logic                 l2r_request_valid;
  l2req_packet_t        l2r_request;
  logic                 l2r_cache_hit;
  l2_way_idx_t          l2r_hit_way;
  cache_line_data_t     l2r_data;
  logic                 l2r_is_l2_fill;
  logic                 l2r_needs_writeback;
  l2_tag_t              l2r_writeback_tag;
  logic                 l2r_store_sync_success;

  l2_cache_read_stage #(.SYNC_SLOTS(16)) dut (
    .clk(clk), .reset(reset),
    .l2t_request_valid(l2t_request_valid), .l2t_request(l2t_request),
    .l2t_valid(l2t_valid), .l2t_tag(l2t_tag), .l2t_dirty(l2t_dirty),
    .l2t_is_l2_fill(l2t_is_l2_fill), .l2t_fill_way(l2t_fill_way),
    .l2t_data_from_memory(l2t_data_from_memory),
    .l2t_is_restarted_flush(l2t_is_restarted_flush),
    .l2u_write_en(l2u_write_en), .l2u_write_index(l2u_write_index),
    .l2u_write_data(l2u_write_data),
    .l2r_update_dirty_en(l2r_update_dirty_en), .l2r_update_dirty_set(l2r_update_dirty_set),
    .l2r_update_dirty_value(l2r_update_dirty_value),
    .l2r_update_tag_en(l2r_update_tag_en), .l2r_update_tag_set(l2r_update_tag_set),
    .l2r_update_tag_valid(l2r_update_tag_valid), .l2r_update_tag_value(l2r_update_tag_value),
    .l2r_update_lru_en(l2r_update_lru_en), .l2r_update_lru_hit_way(l2r_update_lru_hit_way),
    .l2r_request_valid(l2r_request_valid), .l2r_request(l2r_request),
    .l2r_cache_hit(l2r_cache_hit), .l2r_hit_way(l2r_hit_way), .l2r_data(l2r_data),
    .l2r_is_l2_fill(l2r_is_l2_fill), .l2r_needs_writeback(l2r_needs_writeback),
    .l2r_writeback_tag(l2r_writeback_tag), .l2r_store_sync_success(l2r_store_sync_success)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state: reservation table and known SRAM lines.
  bit               mres_v    [16];
  logic [19:0]      mres_line [16];
  cache_line_data_t mmem      [64];
  bit               mknown    [64];
  bit               primed = 0;

  typedef struct {
    logic [3:0]       dirty_en;
    logic             dirty_val;
    logic [3:0]       tag_en;
    logic             tag_valid;
    logic             lru_en;
    l2_way_idx_t      lru_way;
    logic             vld;
    l2req_packet_t    req;
    logic             hit;
    logic             access;
    l2_way_idx_t      way;
    logic             data_ok;
    cache_line_data_t data;
    logic             fill;
    logic             wb;
    l2_tag_t          wb_tag;
    logic             ss_ok;
  } exp_t;

  exp_t exp_r;

  function automatic exp_t predict();
    exp_t e;
    int hw, w, slot, idx;
    logic [19:0] line;
    logic wr;
    e = '{default: '0};
    if (reset || !l2t_request_valid) return e;
    hw = -1;
    for (int i = 0; i < 4; i++)
      if (l2t_valid[i] && l2t_tag[i] == l2t_request.tag) hw = i;
    e.vld    = 1'b1;
    e.req    = l2t_request;
    e.hit    = (hw >= 0);
    e.fill   = l2t_is_l2_fill;
    e.access = e.hit || e.fill;
    w        = e.fill ? int'(l2t_fill_way) : hw;
    e.way    = l2_way_idx_t'(w);
    line     = {l2t_request.tag, l2t_request.set_idx};
    slot     = int'(l2t_request.id) % 16;
    wr       = 1'b0;
    if (e.access) begin
      case (l2t_request.packet_type)
        L2REQ_LOAD, L2REQ_LOAD_SYNC: e.lru_en = 1'b1;
        L2REQ_STORE: begin e.lru_en = 1'b1; wr = 1'b1; end
        L2REQ_STORE_SYNC: begin
          e.lru_en = 1'b1;
          e.ss_ok  = mres_v[slot] && mres_line[slot] == line;
          wr       = e.ss_ok;
        end
        L2REQ_FLUSH:
          if (!e.fill && l2t_dirty[hw]) begin
            e.dirty_en[hw] = 1'b1;
            e.wb     = !l2t_is_restarted_flush;
            e.wb_tag = l2t_tag[hw];
          end
        L2REQ_DINVALIDATE: if (!e.fill) e.tag_en[hw] = 1'b1;
        default: ;
      endcase
    end
    if (wr) begin e.dirty_en[w] = 1'b1; e.dirty_val = 1'b1; end
    if (e.fill) begin
      e.lru_en = 1'b1; e.tag_en[w] = 1'b1; e.tag_valid = 1'b1; e.dirty_en[w] = 1'b1;
      e.wb = l2t_valid[w] && l2t_dirty[w];
      e.wb_tag = l2t_tag[w];
      e.data = l2t_data_from_memory; e.data_ok = 1'b1;
    end else if (e.hit) begin
      idx = hw * 16 + int'(l2t_request.set_idx);
      if (l2u_write_en && int'(l2u_write_index) == idx) begin
        e.data = l2u_write_data; e.data_ok = 1'b1;
      end else if (mknown[idx]) begin
        e.data = mmem[idx]; e.data_ok = 1'b1;
      end
    end
    e.lru_way = e.way;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic [19:0] line;
    int slot;
    e = predict();
    exp_r = e;
    line = {l2t_request.tag, l2t_request.set_idx};
    slot = int'(l2t_request.id) % 16;
    if (reset) begin
      for (int s = 0; s < 16; s++) mres_v[s] = 1'b0;
    end else if (e.vld && e.access) begin
      if ((l2t_request.packet_type == L2REQ_STORE) || e.ss_ok)
        for (int s = 0; s < 16; s++)
          if (mres_v[s] && mres_line[s] == line) mres_v[s] = 1'b0;
      if (l2t_request.packet_type == L2REQ_LOAD_SYNC) begin
        mres_v[slot] = 1'b1; mres_line[slot] = line;
      end
    end
    if (l2u_write_en) begin
      mmem[l2u_write_index] = l2u_write_data;
      mknown[l2u_write_index] = 1'b1;
    end
    primed = 1'b1;
  end

  always @(negedge clk) begin
    exp_t c;
    c = predict();
    chk("m_dirty_en", l2r_update_dirty_en, c.dirty_en);
    if (c.dirty_en != 0) begin
      chk("m_dirty_val", l2r_update_dirty_value, c.dirty_val);
      chk("m_dirty_set", l2r_update_dirty_set, l2t_request.set_idx);
    end
    chk("m_tag_en", l2r_update_tag_en, c.tag_en);
    if (c.tag_en != 0) begin
      chk("m_tag_valid", l2r_update_tag_valid, c.tag_valid);
      chk("m_tag_value", l2r_update_tag_value, l2t_request.tag);
      chk("m_tag_set", l2r_update_tag_set, l2t_request.set_idx);
    end
    chk("m_lru_en", l2r_update_lru_en, c.lru_en);
    if (c.lru_en) chk("m_lru_way", l2r_update_lru_hit_way, c.lru_way);
    if (primed) begin
      chk("m_req_valid", l2r_request_valid, exp_r.vld);
      chk("m_hit", l2r_cache_hit, exp_r.hit);
      chk("m_fill", l2r_is_l2_fill, exp_r.fill);
      chk("m_wb", l2r_needs_writeback, exp_r.wb);
      chk("m_ss", l2r_store_sync_success, exp_r.ss_ok);
      if (exp_r.vld) chk("m_req", l2r_request, exp_r.req);
      if (exp_r.vld && exp_r.access) chk("m_hit_way", l2r_hit_way, exp_r.way);
      if (exp_r.vld && exp_r.data_ok) chk("m_data", l2r_data, exp_r.data);
      if (exp_r.wb) chk("m_wb_tag", l2r_writeback_tag, exp_r.wb_tag);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    l2t_request_valid      = 1'b0;
    l2t_request            = '0;
    l2t_valid              = '0;
    l2t_tag                = '0;
    l2t_dirty              = '0;
    l2t_is_l2_fill         = 1'b0;
    l2t_fill_way           = '0;
    l2t_data_from_memory   = '0;
    l2t_is_restarted_flush = 1'b0;
    l2u_write_en           = 1'b0;
    l2u_write_index        = '0;
    l2u_write_data         = '0;
  endtask

  task automatic set_req(input l2req_type_t t, input logic [5:0] id, input l2_tag_t tg,
                         input l2_set_idx_t s);
    l2t_request_valid = 1'b1;
    l2t_request = '{id: id, packet_type: t, tag: tg, set_idx: s};
  endtask

  task automatic sram_wr(input logic [5:0] idx, input cache_line_data_t d);
    l2u_write_en = 1'b1; l2u_write_index = idx; l2u_write_data = d;
    step();
    l2u_write_en = 1'b0;
  endtask

  localparam cache_line_data_t D23  = {4{32'hD2_03_0001}};
  localparam cache_line_data_t D02  = {4{32'hD0_02_0002}};
  localparam cache_line_data_t D14  = {4{32'hD1_04_0003}};
  localparam cache_line_data_t NEWD = {4{32'hBEEF_0004}};
  localparam cache_line_data_t FILL = {4{32'hF111_0005}};

  initial begin
    clear_inputs();
    // Reset while a store-fill request is presented.
    reset = 1'b1;
    l2t_valid = 4'b0010; l2t_tag[1] = 16'h55; l2t_dirty = 4'b0010;
    l2t_is_l2_fill = 1'b1; l2t_fill_way = 2'd1;
    set_req(L2REQ_STORE, 6'd1, 16'h42, 4'd1);
    #1;
    chk("rst_tag_en", l2r_update_tag_en, 4'b0000);
    chk("rst_dirty_en", l2r_update_dirty_en, 4'b0000);
    chk("rst_lru_en", l2r_update_lru_en, 1'b0);
    step(); step();
    chk("rst_req_valid", l2r_request_valid, 1'b0);
    chk("rst_fill", l2r_is_l2_fill, 1'b0);
    chk("rst_wb", l2r_needs_writeback, 1'b0);
    reset = 1'b0;
    clear_inputs();

    sram_wr({2'd2, 4'd3}, D23);
    sram_wr({2'd0, 4'd2}, D02);
    sram_wr({2'd1, 4'd4}, D14);

    // Load hit in way 2.
    l2t_valid = 4'b0100; l2t_tag[2] = 16'h1234;
    set_req(L2REQ_LOAD, 6'd1, 16'h1234, 4'd3);
    #1;
    chk("t1_lru_en", l2r_update_lru_en, 1'b1);
    chk("t1_lru_way", l2r_update_lru_hit_way, 2'd2);
    step();
    chk("t1_hit", l2r_cache_hit, 1'b1);
    chk("t1_hit_way", l2r_hit_way, 2'd2);
    chk("t1_data", l2r_data, D23);
    clear_inputs();

    // Fill into dirty way 1.
    l2t_valid = 4'b0010; l2t_tag[1] = 16'h55; l2t_dirty = 4'b0010;
    l2t_is_l2_fill = 1'b1; l2t_fill_way = 2'd1; l2t_data_from_memory = FILL;
    set_req(L2REQ_LOAD, 6'd2, 16'h77, 4'd5);
    #1;
    chk("t2_tag_en", l2r_update_tag_en, 4'b0010);
    chk("t2_tag_valid", l2r_update_tag_valid, 1'b1);
    chk("t2_dirty_val", l2r_update_dirty_value, 1'b0);
    step();
    chk("t2_wb", l2r_needs_writeback, 1'b1);
    chk("t2_wb_tag", l2r_writeback_tag, 16'h55);
    chk("t2_data", l2r_data, FILL);
    clear_inputs();

    // Flush hit on dirty way 0, then restarted.
    l2t_valid = 4'b0001; l2t_tag[0] = 16'h99; l2t_dirty = 4'b0001;
    set_req(L2REQ_FLUSH, 6'd4, 16'h99, 4'd6);
    #1;
    chk("t3_dirty_en", l2r_update_dirty_en, 4'b0001);
    chk("t3_dirty_val", l2r_update_dirty_value, 1'b0);
    chk("t3_lru_en", l2r_update_lru_en, 1'b0);
    step();
    chk("t3_wb", l2r_needs_writeback, 1'b1);
    chk("t3_wb_tag", l2r_writeback_tag, 16'h99);
    l2t_is_restarted_flush = 1'b1;
    step();
    chk("t3_wb_restart", l2r_needs_writeback, 1'b0);
    clear_inputs();

    // Load-sync / store-sync pair on line A (tag A0, set 2, way 0).
    l2t_valid = 4'b0001; l2t_tag[0] = 16'h00A0;
    set_req(L2REQ_LOAD_SYNC, 6'd3, 16'h00A0, 4'd2);
    step();
    set_req(L2REQ_STORE_SYNC, 6'd3, 16'h00A0, 4'd2);
    #1;
    chk("t4_dirty_en", l2r_update_dirty_en, 4'b0001);
    chk("t4_dirty_val", l2r_update_dirty_value, 1'b1);
    step();
    chk("t4_ss_ok", l2r_store_sync_success, 1'b1);
    chk("t4b_dirty_en", l2r_update_dirty_en, 4'b0000);
    step();
    chk("t4b_ss_fail", l2r_store_sync_success, 1'b0);

    // Two reservations on A, killed by a plain store from another id.
    set_req(L2REQ_LOAD_SYNC, 6'd3, 16'h00A0, 4'd2); step();
    set_req(L2REQ_LOAD_SYNC, 6'd5, 16'h00A0, 4'd2); step();
    set_req(L2REQ_STORE, 6'd7, 16'h00A0, 4'd2); step();
    set_req(L2REQ_STORE_SYNC, 6'd5, 16'h00A0, 4'd2);
    #1;
    chk("t5_dirty_en", l2r_update_dirty_en, 4'b0000);
    step();
    chk("t5_ss5", l2r_store_sync_success, 1'b0);
    set_req(L2REQ_STORE_SYNC, 6'd3, 16'h00A0, 4'd2); step();
    chk("t5_ss3", l2r_store_sync_success, 1'b0);

    // Slot index wraps: id 19 shares slot 3.
    set_req(L2REQ_LOAD_SYNC, 6'd19, 16'h00A0, 4'd2); step();
    set_req(L2REQ_STORE_SYNC, 6'd3, 16'h00A0, 4'd2); step();
    chk("t5_wrap_ss", l2r_store_sync_success, 1'b1);
    clear_inputs();

    // Read hit while the update stage writes the same line.
    l2t_valid = 4'b0010; l2t_tag[1] = 16'h00BB;
    set_req(L2REQ_LOAD, 6'd8, 16'h00BB, 4'd4);
    l2u_write_en = 1'b1; l2u_write_index = {2'd1, 4'd4}; l2u_write_data = NEWD;
    step();
    chk("t6_bypass", l2r_data, NEWD);
    clear_inputs();

    // Invalidate hit and store miss without fill.
    l2t_valid = 4'b0100; l2t_tag[2] = 16'h1234;
    set_req(L2REQ_DINVALIDATE, 6'd9, 16'h1234, 4'd3);
    #1;
    chk("t7_tag_en", l2r_update_tag_en, 4'b0100);
    chk("t7_tag_valid", l2r_update_tag_valid, 1'b0);
    step();
    set_req(L2REQ_STORE, 6'd10, 16'h0333, 4'd7);
    l2t_valid = 4'b0000;
    step();
    chk("t8_miss_hit", l2r_cache_hit, 1'b0);
    chk("t8_miss_vld", l2r_request_valid, 1'b1);
    clear_inputs();

    // Reset mid-request wipes reservations.
    l2t_valid = 4'b0001; l2t_tag[0] = 16'h00A0;
    set_req(L2REQ_LOAD_SYNC, 6'd3, 16'h00A0, 4'd2); step();
    reset = 1'b1;
    set_req(L2REQ_STORE, 6'd7, 16'h00A0, 4'd2);
    #1;
    chk("t9_rst_dirty_en", l2r_update_dirty_en, 4'b0000);
    step();
    chk("t9_rst_vld", l2r_request_valid, 1'b0);
    chk("t9_rst_hit", l2r_cache_hit, 1'b0);
    reset = 1'b0;
    set_req(L2REQ_STORE_SYNC, 6'd3, 16'h00A0, 4'd2); step();
    chk("t9_ss_after_rst", l2r_store_sync_success, 1'b0);
    clear_inputs();
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
